// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
// Multi-cycle control unit for the 32-bit datapath. It sequences fetch,
// decode and execute, and drives the datapath strobes as a registered
// (Moore) control word.
//
// Parameters:
//   NREG          number of general registers (width of R_enableIn)
//   LINK_REG      register written by jal
//   MEM_HANDSHAKE 1: stall on Mem_ready; 0: memory is always ready
// Ports:
//   Clock, Reset_n  rising-edge clock, asynchronous active-low reset
//   IR              instruction register; opcode = IR[31:27]
//   Mem_ready       memory finished the current read or write
//   CON_ff          branch condition flip-flop
//   Stop / Start    halt at the next instruction boundary / resume from HALT
//   Ctrl            28 datapath strobes (bit map in the localparams below)
//   R_enableIn      one-hot register write enable (jal link write only)
//   Run             processor running
//   Illegal         sticky undefined-opcode flag
//   State           current state code
//
// Handshake: Mem_ready is sampled on the edge that would leave a waiting
// state (F1, ld T6, st T7); while it is low the state, and therefore the
// strobes, hold unchanged.
module cpu_control_fsm #(
    parameter int NREG          = 16,
    parameter int LINK_REG      = 15,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [31:0]     IR,
    input  logic            Mem_ready,
    input  logic            CON_ff,
    input  logic            Stop,
    input  logic            Start,
    output logic [27:0]     Ctrl,
    output logic [NREG-1:0] R_enableIn,
    output logic            Run,
    output logic            Illegal,
    output logic [7:0]      State
);

    typedef enum logic [7:0] {
        S_RST  = 8'd0,
        S_F0   = 8'd1,
        S_F1   = 8'd2,
        S_F2   = 8'd3,
        S_DEC  = 8'd4,
        S_T3   = 8'd5,
        S_T4   = 8'd6,
        S_T5   = 8'd7,
        S_T6   = 8'd8,
        S_T7   = 8'd9,
        S_HALT = 8'd10
    } state_t;

    // Ctrl bit positions
    localparam int PCOUT = 0,  ZHIGHOUT = 1,  ZLOWOUT = 2,  MDROUT = 3;
    localparam int MARIN = 4,  PCIN = 5,      MDRIN = 6,    IRIN = 7;
    localparam int YIN = 8,    INCPC = 9,     READ = 10,    HIIN = 11;
    localparam int LOIN = 12,  HIOUT = 13,    LOOUT = 14,   ZHIGHIN = 15;
    localparam int ZLOWIN = 16, COUT = 17,    WRITE = 18,   GRA = 19;
    localparam int GRB = 20,   GRC = 21,      RIN = 22,     ROUT = 23;
    localparam int BAOUT = 24, CONIN = 25,    OUTPORTIN = 26, INPORTOUT = 27;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010, OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100, OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110, OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000, OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010, OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110, OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000, OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010, OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100, OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110, OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000, OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    state_t            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic              stop_pending_q, stop_pending_d;
    logic              illegal_q, illegal_d;
    logic [27:0]       ctrl_q, ctrl_d;
    logic [NREG-1:0]   ren_q, ren_d;
    logic              run_q, run_d;
    logic              mem_rdy;
    logic              stop_now;
    logic              unused_ir;

    assign mem_rdy   = (MEM_HANDSHAKE == 0) ? 1'b1 : Mem_ready;
    assign unused_ir = ^IR[26:0];
    assign stop_now  = stop_pending_q | Stop;

    // Last execute state of each instruction.
    function automatic state_t last_state(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:   last_state = S_T5;
            OP_MUL, OP_DIV, OP_BR:              last_state = S_T6;
            OP_NEG, OP_NOT, OP_JAL:             last_state = S_T4;
            OP_LD, OP_ST:                       last_state = S_T7;
            default:                            last_state = S_T3;
        endcase
    endfunction

    // Strobes for a given state; evaluated on the next state so the
    // registered Ctrl matches the state the machine is entering.
    function automatic logic [27:0] decode_ctrl(input state_t st,
                                                input logic [4:0] op,
                                                input logic con);
        logic [27:0] c;
        c = '0;
        case (st)
            S_F0: begin c[PCOUT] = 1'b1; c[MARIN] = 1'b1; end
            S_F1: begin c[READ] = 1'b1; c[MDRIN] = 1'b1; end
            S_F2: begin
                c[MDROUT] = 1'b1; c[IRIN] = 1'b1; c[INCPC] = 1'b1; c[PCIN] = 1'b1;
            end
            S_T3: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
                    OP_MUL, OP_DIV, OP_ADDI, OP_ANDI, OP_ORI: begin
                        c[GRB] = 1'b1; c[ROUT] = 1'b1; c[YIN] = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        c[GRB] = 1'b1; c[ROUT] = 1'b1; c[ZHIGHIN] = 1'b1; c[ZLOWIN] = 1'b1;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        c[GRB] = 1'b1; c[BAOUT] = 1'b1; c[YIN] = 1'b1;
                    end
                    OP_BR:   begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[CONIN] = 1'b1; end
                    OP_JR:   begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[PCIN] = 1'b1; end
                    OP_JAL:  c[PCOUT] = 1'b1;
                    OP_MFHI: begin c[GRA] = 1'b1; c[RIN] = 1'b1; c[HIOUT] = 1'b1; end
                    OP_MFLO: begin c[GRA] = 1'b1; c[RIN] = 1'b1; c[LOOUT] = 1'b1; end
                    OP_IN:   begin c[GRA] = 1'b1; c[RIN] = 1'b1; c[INPORTOUT] = 1'b1; end
                    OP_OUT:  begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[OUTPORTIN] = 1'b1; end
                    default: c = '0;
                endcase
            end
            S_T4: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
                    OP_MUL, OP_DIV: begin
                        c[GRC] = 1'b1; c[ROUT] = 1'b1; c[ZHIGHIN] = 1'b1; c[ZLOWIN] = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin c[ZLOWOUT] = 1'b1; c[GRA] = 1'b1; c[RIN] = 1'b1; end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
                        c[COUT] = 1'b1; c[ZHIGHIN] = 1'b1; c[ZLOWIN] = 1'b1;
                    end
                    OP_BR:   begin c[PCOUT] = 1'b1; c[YIN] = 1'b1; end
                    OP_JAL:  begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[PCIN] = 1'b1; end
                    default: c = '0;
                endcase
            end
            S_T5: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        c[ZLOWOUT] = 1'b1; c[GRA] = 1'b1; c[RIN] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin c[ZLOWOUT] = 1'b1; c[LOIN] = 1'b1; end
                    OP_LD, OP_ST:   begin c[ZLOWOUT] = 1'b1; c[MARIN] = 1'b1; end
                    OP_BR: begin c[COUT] = 1'b1; c[ZHIGHIN] = 1'b1; c[ZLOWIN] = 1'b1; end
                    default: c = '0;
                endcase
            end
            S_T6: begin
                case (op)
                    OP_MUL, OP_DIV: begin c[ZHIGHOUT] = 1'b1; c[HIIN] = 1'b1; end
                    OP_LD: begin c[READ] = 1'b1; c[MDRIN] = 1'b1; end
                    OP_ST: begin c[GRA] = 1'b1; c[ROUT] = 1'b1; c[MDRIN] = 1'b1; end
                    // Branch taken only when the condition flop is set.
                    OP_BR: begin c[ZLOWOUT] = con; c[PCIN] = con; end
                    default: c = '0;
                endcase
            end
            S_T7: begin
                case (op)
                    OP_LD: begin c[MDROUT] = 1'b1; c[GRA] = 1'b1; c[RIN] = 1'b1; end
                    OP_ST: begin c[MDROUT] = 1'b1; c[WRITE] = 1'b1; end
                    default: c = '0;
                endcase
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic and registered-output decode.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        stop_pending_d = stop_pending_q | Stop;
        illegal_d      = illegal_q;

        case (state_q)
            S_RST: begin
                if (stop_now) begin
                    state_d        = S_HALT;
                    stop_pending_d = 1'b0;
                end else begin
                    state_d = S_F0;
                end
            end
            S_F0:  state_d = S_F1;
            S_F1:  if (mem_rdy) state_d = S_F2;
            S_F2:  state_d = S_DEC;
            S_DEC: begin
                op_d = IR[31:27];
                if (IR[31:27] == OP_HALT) begin
                    state_d        = S_HALT;
                    stop_pending_d = 1'b0;
                end else if (IR[31:27] > OP_HALT) begin
                    state_d        = S_HALT;
                    illegal_d      = 1'b1;
                    stop_pending_d = 1'b0;
                end else begin
                    state_d = S_T3;
                end
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if ((state_q == S_T6 && op_q == OP_LD && !mem_rdy) ||
                    (state_q == S_T7 && op_q == OP_ST && !mem_rdy)) begin
                    state_d = state_q;
                end else if (state_q == last_state(op_q)) begin
                    // Instruction boundary: honour any pending stop here.
                    if (stop_now) begin
                        state_d        = S_HALT;
                        stop_pending_d = 1'b0;
                    end else begin
                        state_d = S_F0;
                    end
                end else begin
                    case (state_q)
                        S_T3:    state_d = S_T4;
                        S_T4:    state_d = S_T5;
                        S_T5:    state_d = S_T6;
                        default: state_d = S_T7;
                    endcase
                end
            end
            S_HALT: begin
                // A stop request while already halted is satisfied.
                stop_pending_d = 1'b0;
                if (Start && !Stop) state_d = S_F0;
            end
            default: state_d = S_RST;
        endcase

        ctrl_d = decode_ctrl(state_d, op_d, CON_ff);
        ren_d  = '0;
        if (state_d == S_T3 && op_d == OP_JAL) ren_d[LINK_REG] = 1'b1;
        run_d  = (state_d != S_RST) && (state_d != S_HALT);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= S_RST;
            op_q           <= '0;
            stop_pending_q <= 1'b0;
            illegal_q      <= 1'b0;
            ctrl_q         <= '0;
            ren_q          <= '0;
            run_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            stop_pending_q <= stop_pending_d;
            illegal_q      <= illegal_d;
            ctrl_q         <= ctrl_d;
            ren_q          <= ren_d;
            run_q          <= run_d;
        end
    end

    assign Ctrl       = ctrl_q;
    assign R_enableIn = ren_q;
    assign Run        = run_q;
    assign Illegal    = illegal_q;
    assign State      = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm (NREG=32, LINK_REG=31).
module tb_cpu_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir;
  logic        mem_ready;
  logic        con_ff;
  logic        stop;
  logic        start;
  logic [27:0] ctrl;
  logic [31:0] r_enable;
  logic        run;
  logic        illegal;
  logic [7:0]  state;

  int checks;
  int failures;

  // Ctrl bit values
  localparam logic [31:0] PCOUT = 32'h1 << 0, ZHIGHOUT = 32'h1 << 1, ZLOWOUT = 32'h1 << 2;
  localparam logic [31:0] MDROUT = 32'h1 << 3, MARIN = 32'h1 << 4, PCIN = 32'h1 << 5;
  localparam logic [31:0] MDRIN = 32'h1 << 6, IRIN = 32'h1 << 7, YIN = 32'h1 << 8;
  localparam logic [31:0] INCPC = 32'h1 << 9, READ = 32'h1 << 10, HIIN = 32'h1 << 11;
  localparam logic [31:0] LOIN = 32'h1 << 12, ZHIGHIN = 32'h1 << 15, ZLOWIN = 32'h1 << 16;
  localparam logic [31:0] COUT = 32'h1 << 17, WRITE = 32'h1 << 18, GRA = 32'h1 << 19;
  localparam logic [31:0] GRB = 32'h1 << 20, GRC = 32'h1 << 21, RIN = 32'h1 << 22;
  localparam logic [31:0] ROUT = 32'h1 << 23, BAOUT = 32'h1 << 24, CONIN = 32'h1 << 25;

  localparam logic [31:0] S_RST = 0, S_F0 = 1, S_F1 = 2, S_F2 = 3, S_DEC = 4;
  localparam logic [31:0] S_T3 = 5, S_T4 = 6, S_T5 = 7, S_T6 = 8, S_T7 = 9, S_HALT = 10;

  cpu_control_fsm #(.NREG(32), .LINK_REG(31), .MEM_HANDSHAKE(1)) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .IR        (ir),
    .Mem_ready (mem_ready),
    .CON_ff    (con_ff),
    .Stop      (stop),
    .Start     (start),
    .Ctrl      (ctrl),
    .R_enableIn(r_enable),
    .Run       (run),
    .Illegal   (illegal),
    .State     (state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock, sample 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_to_dec();
    step(); chk("f1_ctrl", {4'b0, ctrl}, READ | MDRIN);
    step(); chk("f2_ctrl", {4'b0, ctrl}, MDROUT | IRIN | INCPC | PCIN);
    step(); chk("dec_ctrl", {4'b0, ctrl}, 32'h0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    ir        = 32'h0;
    mem_ready = 1'b1;
    con_ff    = 1'b0;
    stop      = 1'b0;
    start     = 1'b0;

    // reset state
    #12;
    chk("rst_state", {24'b0, state}, S_RST);
    chk("rst_ctrl", {4'b0, ctrl}, 32'h0);
    chk("rst_run", {31'b0, run}, 32'h0);
    chk("rst_illegal", {31'b0, illegal}, 32'h0);
    chk("rst_ren", r_enable, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset: F0, running
    step();
    chk("f0_state", {24'b0, state}, S_F0);
    chk("f0_ctrl", {4'b0, ctrl}, PCOUT | MARIN);
    chk("f0_run", {31'b0, run}, 32'h1);

    // add: 7 cycles F0 to F0
    ir = 32'h18000000;
    fetch_to_dec();
    step(); chk("add_t3", {4'b0, ctrl}, GRB | ROUT | YIN);
    step(); chk("add_t4", {4'b0, ctrl}, GRC | ROUT | ZHIGHIN | ZLOWIN);
    step(); chk("add_t5", {4'b0, ctrl}, 32'h00480004);
    step(); chk("add_next_f0", {24'b0, state}, S_F0);

    // ld with Mem_ready low for 3 cycles in T6
    ir = 32'h00000000;
    fetch_to_dec();
    step(); chk("ld_t3", {4'b0, ctrl}, GRB | BAOUT | YIN);
    step(); chk("ld_t4", {4'b0, ctrl}, COUT | ZHIGHIN | ZLOWIN);
    step(); chk("ld_t5", {4'b0, ctrl}, ZLOWOUT | MARIN);
    step(); chk("ld_t6_entry", {4'b0, ctrl}, READ | MDRIN);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_t6_hold_state", {24'b0, state}, S_T6);
      chk("ld_t6_hold_ctrl", {4'b0, ctrl}, READ | MDRIN);
    end
    mem_ready = 1'b1;
    step(); chk("ld_t7", {4'b0, ctrl}, MDROUT | GRA | RIN);
    step(); chk("ld_next_f0", {24'b0, state}, S_F0);

    // br not taken
    ir = 32'h90000000;
    con_ff = 1'b0;
    fetch_to_dec();
    step(); chk("br_t3", {4'b0, ctrl}, GRA | ROUT | CONIN);
    step(); chk("br_t4", {4'b0, ctrl}, PCOUT | YIN);
    step(); chk("br_t5", {4'b0, ctrl}, COUT | ZHIGHIN | ZLOWIN);
    step();
    chk("br0_t6_state", {24'b0, state}, S_T6);
    chk("br0_t6_ctrl", {4'b0, ctrl}, 32'h0);
    step(); chk("br0_next_f0", {24'b0, state}, S_F0);

    // br taken
    con_ff = 1'b1;
    fetch_to_dec();
    step(); step(); step(); step();
    chk("br1_t6_ctrl", {4'b0, ctrl}, 32'h00000024);
    step(); chk("br1_next_f0", {24'b0, state}, S_F0);
    con_ff = 1'b0;

    // jal: link register one-hot only in T3
    ir = 32'hA0000000;
    fetch_to_dec();
    step();
    chk("jal_t3_ctrl", {4'b0, ctrl}, PCOUT);
    chk("jal_t3_ren", r_enable, 32'h80000000);
    step();
    chk("jal_t4_ctrl", {4'b0, ctrl}, GRA | ROUT | PCIN);
    chk("jal_t4_ren", r_enable, 32'h0);
    step(); chk("jal_next_f0", {24'b0, state}, S_F0);

    // mul with Stop pulsed in T4: finishes, then HALT
    ir = 32'h70000000;
    fetch_to_dec();
    step(); step();
    chk("mul_t4_state", {24'b0, state}, S_T4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("mul_t5_ctrl", {4'b0, ctrl}, ZLOWOUT | LOIN);
    step();
    chk("mul_t6_ctrl", {4'b0, ctrl}, ZHIGHOUT | HIIN);
    chk("mul_t6_run", {31'b0, run}, 32'h1);
    step();
    chk("stop_halt_state", {24'b0, state}, S_HALT);
    chk("stop_halt_run", {31'b0, run}, 32'h0);
    chk("stop_halt_ctrl", {4'b0, ctrl}, 32'h0);
    start = 1'b1;
    stop  = 1'b1;
    step(); chk("start_stop_hold", {24'b0, state}, S_HALT);
    stop = 1'b0;
    step();
    start = 1'b0;
    chk("start_f0_state", {24'b0, state}, S_F0);
    chk("start_f0_run", {31'b0, run}, 32'h1);

    // illegal opcode
    ir = 32'hF8000000;
    fetch_to_dec();
    step();
    chk("ill_state", {24'b0, state}, S_HALT);
    chk("ill_flag", {31'b0, illegal}, 32'h1);
    chk("ill_run", {31'b0, run}, 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ill_resume_f0", {24'b0, state}, S_F0);
    chk("ill_sticky", {31'b0, illegal}, 32'h1);

    // st, stall in T7, then asynchronous reset
    ir = 32'h10000000;
    fetch_to_dec();
    step(); step(); step();
    step(); chk("st_t6", {4'b0, ctrl}, GRA | ROUT | MDRIN);
    mem_ready = 1'b0;
    step(); chk("st_t7", {4'b0, ctrl}, MDROUT | WRITE);
    step(); chk("st_t7_hold", {24'b0, state}, S_T7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {4'b0, ctrl}, 32'h0);
    chk("arst_state", {24'b0, state}, S_RST);
    chk("arst_illegal", {31'b0, illegal}, 32'h0);
    chk("arst_run", {31'b0, run}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
